// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// FSM states and datapath mux/ALU select values. JALEX exists only with MC_CONTROLLER_JAL_EN.
package mc_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_MULTU  = 6'b011001;
  localparam logic [5:0] F_MFHI   = 6'b010000;
  localparam logic [5:0] F_MFLO   = 6'b010010;
  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_HILO   = 2'b10;
  localparam logic [1:0] MTR_PC     = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX, S_MULT
`ifdef MC_CONTROLLER_JAL_EN
    , S_JALEX
`endif
  } state_t;

endpackage

// File: rtl/mc_controller_if.sv
// Datapath-facing bundle of the controller: decoded fields and flags in,
// mux selects and write enables out.
interface mc_controller_if #(parameter int ALUCTL_W = 3);
  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                pcen;
  logic [1:0]          pcsrc;
  logic                iord;
  logic                memwrite;
  logic                irwrite;
  logic                regwrite;
  logic [1:0]          regdst;
  logic [1:0]          memtoreg;
  logic                alusrca;
  logic [1:0]          alusrcb;
  logic [ALUCTL_W-1:0] alucontrol;
  logic                mult_start;
  logic                hilosel;
  logic                busy;

  modport master (
    output op, funct, zero, mem_ready,
    input  pcen, pcsrc, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, alucontrol, mult_start, hilosel, busy
  );

  modport slave (
    input  op, funct, zero, mem_ready,
    output pcen, pcsrc, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, alucontrol, mult_start, hilosel, busy
  );
endinterface

// File: rtl/mc_aludec.sv
// R-type funct to ALU operation decode; anything that is not a plain ALU op
// (multu, mfhi, jr, ...) falls back to add.
module mc_aludec
  import mc_controller_pkg::*;
#(
  parameter int ALUCTL_W = 3
) (
  input  logic [5:0]          i_funct,
  output logic [ALUCTL_W-1:0] o_alucontrol
);

  logic [2:0] w_alu;

  always_comb begin
    w_alu = ALU_ADD;
    case (i_funct)
      F_ADD:   w_alu = ALU_ADD;
      F_SUB:   w_alu = ALU_SUB;
      F_AND:   w_alu = ALU_AND;
      F_OR:    w_alu = ALU_OR;
      F_SLT:   w_alu = ALU_SLT;
      default: w_alu = ALU_ADD;
    endcase
  end

  assign o_alucontrol = ALUCTL_W'(w_alu);

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with iterative-multiply wait state.
// Optional jal support is enabled by defining MC_CONTROLLER_JAL_EN.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int ALUCTL_W    = 3
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.slave  bus
);

  localparam int                  CNT_W    = $clog2(MULT_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [ALUCTL_W-1:0] ALUC_ADD = ALUCTL_W'(ALU_ADD);
  localparam logic [ALUCTL_W-1:0] ALUC_SUB = ALUCTL_W'(ALU_SUB);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [ALUCTL_W-1:0] w_rtype_alu;

  logic                w_pcen;
  logic [1:0]          w_pcsrc;
  logic                w_iord;
  logic                w_memwrite;
  logic                w_irwrite;
  logic                w_regwrite;
  logic [1:0]          w_regdst;
  logic [1:0]          w_memtoreg;
  logic                w_alusrca;
  logic [1:0]          w_alusrcb;
  logic [ALUCTL_W-1:0] w_alucontrol;
  logic                w_mult_start;
  logic                w_hilosel;
  logic                w_busy;

  mc_aludec #(.ALUCTL_W(ALUCTL_W)) u_aludec (
    .i_funct      (bus.funct),
    .o_alucontrol (w_rtype_alu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // counter runs only while staying in MULT, so each entry starts from 0
      if (r_state == S_MULT && w_next == S_MULT) r_cnt <= r_cnt + CNT_W'(1);
      else                                       r_cnt <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pcen       = 1'b0;
    w_pcsrc      = PCS_ALU;
    w_iord       = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_regwrite   = 1'b0;
    w_regdst     = RD_RT;
    w_memtoreg   = MTR_ALUOUT;
    w_alusrca    = 1'b0;
    w_alusrcb    = SRCB_REG;
    w_alucontrol = '0;
    w_mult_start = 1'b0;
    w_hilosel    = 1'b0;
    w_busy       = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_alusrcb    = SRCB_FOUR;
        w_alucontrol = ALUC_ADD;
        if (bus.mem_ready) begin
          w_irwrite = 1'b1;
          w_pcen    = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alusrcb    = SRCB_SHIMM;
        w_alucontrol = ALUC_ADD;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef MC_CONTROLLER_JAL_EN
          OP_JAL:       w_next = S_JALEX;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = SRCB_IMM;
        w_alucontrol = ALUC_ADD;
        w_next       = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_regdst   = RD_RT;
        w_memtoreg = MTR_MDR;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (bus.mem_ready) w_next = S_FETCH;
      end
      S_RTYPEEX: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = SRCB_REG;
        w_alucontrol = w_rtype_alu;
        case (bus.funct)
          F_MULTU: begin
            w_mult_start = 1'b1;
            w_next       = S_MULT;
          end
          F_JR: begin
            w_pcen  = 1'b1;
            w_pcsrc = PCS_REG;
            w_next  = S_FETCH;
          end
          default: w_next = S_RTYPEWB;
        endcase
      end
      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        w_regdst   = RD_RD;
        if (bus.funct == F_MFHI || bus.funct == F_MFLO) begin
          w_memtoreg = MTR_HILO;
          w_hilosel  = (bus.funct == F_MFHI);
        end
        w_next = S_FETCH;
      end
      S_BEQEX: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = SRCB_REG;
        w_alucontrol = ALUC_SUB;
        w_pcsrc      = PCS_ALUOUT;
        w_pcen       = bus.zero;
        w_next       = S_FETCH;
      end
      S_ADDIEX: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = SRCB_IMM;
        w_alucontrol = ALUC_ADD;
        w_next       = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_regdst   = RD_RT;
        w_memtoreg = MTR_ALUOUT;
        w_next     = S_FETCH;
      end
      S_JEX: begin
        w_pcen  = 1'b1;
        w_pcsrc = PCS_JUMP;
        w_next  = S_FETCH;
      end
      S_MULT: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_LAST) w_next = S_FETCH;
      end
`ifdef MC_CONTROLLER_JAL_EN
      S_JALEX: begin
        w_regdst   = RD_RA;
        w_memtoreg = MTR_PC;
        w_regwrite = 1'b1;
        w_pcen     = 1'b1;
        w_pcsrc    = PCS_JUMP;
        w_next     = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase

    // state is already FETCH while reset is high; block the mem_ready-driven enables too
    if (reset) begin
      w_pcen    = 1'b0;
      w_irwrite = 1'b0;
      w_next    = S_FETCH;
    end
  end

  assign bus.pcen       = w_pcen;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.iord       = w_iord;
  assign bus.memwrite   = w_memwrite;
  assign bus.irwrite    = w_irwrite;
  assign bus.regwrite   = w_regwrite;
  assign bus.regdst     = w_regdst;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.alucontrol = w_alucontrol;
  assign bus.mult_start = w_mult_start;
  assign bus.hilosel    = w_hilosel;
  assign bus.busy       = w_busy;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-instruction micro-sequence model,
// per-cycle output compare, and literal checks on recorded output history.
module tb_mc_controller;
  import mc_controller_pkg::*;

  localparam int MC = 4;

  typedef struct packed {
    logic       pcen;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluc;
    logic       ms;
    logic       hilosel;
    logic       busy;
  } ov_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_controller_if #(.ALUCTL_W(3)) bus ();

  mc_controller #(.MULT_CYCLES(MC), .ALUCTL_W(3)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int  n_chk = 0;
  int  n_err = 0;
  logic chk_en = 1'b0;
  ov_t exp_v;
  ov_t w_act;
  ov_t hist[$];

  always_comb begin
    w_act          = '0;
    w_act.pcen     = bus.pcen;
    w_act.pcsrc    = bus.pcsrc;
    w_act.iord     = bus.iord;
    w_act.memwrite = bus.memwrite;
    w_act.irwrite  = bus.irwrite;
    w_act.regwrite = bus.regwrite;
    w_act.regdst   = bus.regdst;
    w_act.memtoreg = bus.memtoreg;
    w_act.alusrca  = bus.alusrca;
    w_act.alusrcb  = bus.alusrcb;
    w_act.aluc     = bus.alucontrol;
    w_act.ms       = bus.mult_start;
    w_act.hilosel  = bus.hilosel;
    w_act.busy     = bus.busy;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (w_act !== exp_v) begin
        n_err++;
        $display("FAIL cycle t=%0t op=%b funct=%b got=%h want=%h",
                 $time, bus.op, bus.funct, w_act, exp_v);
      end
      hist.push_back(w_act);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // expected output vectors, one per control step, straight from the signal tables
  function automatic ov_t f_fetch(input logic mr);
    ov_t v = '0;
    v.alusrcb = 2'b01; v.aluc = 3'b010; v.pcen = mr; v.irwrite = mr;
    return v;
  endfunction
  function automatic ov_t f_dec();
    ov_t v = '0;
    v.alusrcb = 2'b11; v.aluc = 3'b010;
    return v;
  endfunction
  function automatic ov_t f_adr();
    ov_t v = '0;
    v.alusrca = 1'b1; v.alusrcb = 2'b10; v.aluc = 3'b010;
    return v;
  endfunction
  function automatic ov_t f_mem(input logic wr);
    ov_t v = '0;
    v.iord = 1'b1; v.memwrite = wr;
    return v;
  endfunction
  function automatic ov_t f_memwb();
    ov_t v = '0;
    v.regwrite = 1'b1; v.memtoreg = 2'b01;
    return v;
  endfunction
  function automatic ov_t f_rex(input logic [5:0] fn);
    ov_t v = '0;
    v.alusrca = 1'b1;
    case (fn)
      6'b100010: v.aluc = 3'b110;
      6'b100100: v.aluc = 3'b000;
      6'b100101: v.aluc = 3'b001;
      6'b101010: v.aluc = 3'b111;
      default:   v.aluc = 3'b010;
    endcase
    if (fn == 6'b011001) v.ms = 1'b1;
    if (fn == 6'b001000) begin v.pcen = 1'b1; v.pcsrc = 2'b11; end
    return v;
  endfunction
  function automatic ov_t f_rwb(input logic [5:0] fn);
    ov_t v = '0;
    v.regwrite = 1'b1; v.regdst = 2'b01;
    if (fn == 6'b010000) begin v.memtoreg = 2'b10; v.hilosel = 1'b1; end
    if (fn == 6'b010010) v.memtoreg = 2'b10;
    return v;
  endfunction
  function automatic ov_t f_beq(input logic z);
    ov_t v = '0;
    v.alusrca = 1'b1; v.aluc = 3'b110; v.pcsrc = 2'b01; v.pcen = z;
    return v;
  endfunction
  function automatic ov_t f_addiwb();
    ov_t v = '0;
    v.regwrite = 1'b1;
    return v;
  endfunction
  function automatic ov_t f_jex();
    ov_t v = '0;
    v.pcen = 1'b1; v.pcsrc = 2'b10;
    return v;
  endfunction
  function automatic ov_t f_mult();
    ov_t v = '0;
    v.busy = 1'b1;
    return v;
  endfunction
  function automatic ov_t f_jal();
    ov_t v = '0;
    v.regdst = 2'b10; v.memtoreg = 2'b11; v.regwrite = 1'b1; v.pcen = 1'b1; v.pcsrc = 2'b10;
    return v;
  endfunction

  task automatic step(input ov_t e, input logic mr, input logic z);
    bus.mem_ready = mr;
    bus.zero      = z;
    exp_v         = e;
    chk_en        = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // one instruction: its micro-sequence is derived from instruction class only
  task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                       input int fwait, input int mwait, input logic z);
    hist.delete();
    bus.op = op; bus.funct = fn;
    for (int i = 0; i < fwait; i++) step(f_fetch(1'b0), 1'b0, z);
    step(f_fetch(1'b1), 1'b1, z);
    step(f_dec(), 1'b1, z);
    case (op)
      6'b100011, 6'b101011: begin
        step(f_adr(), 1'b1, z);
        for (int i = 0; i < mwait; i++) step(f_mem(op == 6'b101011), 1'b0, z);
        step(f_mem(op == 6'b101011), 1'b1, z);
        if (op == 6'b100011) step(f_memwb(), 1'b1, z);
      end
      6'b000000: begin
        step(f_rex(fn), 1'b1, z);
        if (fn == 6'b011001) for (int i = 0; i < MC; i++) step(f_mult(), 1'b1, z);
        else if (fn != 6'b001000) step(f_rwb(fn), 1'b1, z);
      end
      6'b000100: step(f_beq(z), 1'b1, z);
      6'b001000: begin step(f_adr(), 1'b1, z); step(f_addiwb(), 1'b1, z); end
      6'b000010: step(f_jex(), 1'b1, z);
`ifdef MC_CONTROLLER_JAL_EN
      6'b000011: step(f_jal(), 1'b1, z);
`endif
      default: ;
    endcase
  endtask

  task automatic async_reset(input string name);
    ov_t rv = f_fetch(1'b0);
    chk_en = 1'b0;
    bus.mem_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk({name, "-vec"}, 32'(w_act), 32'(rv));
    chk({name, "-busy"}, 32'(bus.busy), 32'd0);
    chk({name, "-state"}, 32'(dut.r_state == S_FETCH), 32'd1);
    chk({name, "-cnt"}, 32'(dut.r_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk({name, "-held"}, 32'(w_act), 32'(rv));
    rst = 1'b0;
  endtask

  int cnt;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #3;
    chk("reset-vec", 32'(w_act), 32'(f_fetch(1'b0)));
    @(posedge clk); #1;
    rst = 1'b0;

    instr(OP_RTYPE, F_ADD, 0, 0, 1'b0);
    chk("add-len", hist.size(), 4);
    chk("add-regwrite", 32'(hist[3].regwrite), 32'd1);
    chk("add-regdst", 32'(hist[3].regdst), 32'b01);
    instr(OP_RTYPE, F_SUB, 0, 0, 1'b0);
    chk("sub-aluc", 32'(hist[2].aluc), 32'b110);
    instr(OP_RTYPE, F_AND, 0, 0, 1'b0);
    instr(OP_RTYPE, F_OR,  0, 0, 1'b0);
    instr(OP_RTYPE, F_SLT, 2, 0, 1'b0);
    chk("slt-aluc", 32'(hist[4].aluc), 32'b111);

    instr(OP_LW, 6'd0, 0, 3, 1'b0);
    cnt = 0;
    foreach (hist[i]) if (hist[i].iord) cnt++;
    chk("lw-memrd-cycles", cnt, 4);
    chk("lw-memtoreg", 32'(hist[hist.size()-1].memtoreg), 32'b01);
    instr(OP_SW, 6'd0, 0, 1, 1'b0);
    cnt = 0;
    foreach (hist[i]) if (hist[i].memwrite) cnt++;
    chk("sw-memwrite-cycles", cnt, 2);

    instr(OP_BEQ, 6'd0, 0, 0, 1'b1);
    chk("beq1-pcen", 32'(hist[2].pcen), 32'd1);
    chk("beq1-pcsrc", 32'(hist[2].pcsrc), 32'b01);
    instr(OP_BEQ, 6'd0, 0, 0, 1'b0);
    chk("beq0-pcen", 32'(hist[2].pcen), 32'd0);

    instr(OP_ADDI, 6'd0, 0, 0, 1'b0);
    instr(OP_J, 6'd0, 0, 0, 1'b0);

    instr(OP_RTYPE, F_MULTU, 0, 0, 1'b0);
    cnt = 0;
    foreach (hist[i]) if (hist[i].busy) cnt++;
    chk("multu-busy-cycles", cnt, 4);
    cnt = 0;
    foreach (hist[i]) if (hist[i].ms) cnt++;
    chk("multu-start-pulses", cnt, 1);
    instr(OP_RTYPE, F_MFHI, 0, 0, 1'b0);
    chk("mfhi-memtoreg", 32'(hist[3].memtoreg), 32'b10);
    chk("mfhi-hilosel", 32'(hist[3].hilosel), 32'd1);
    instr(OP_RTYPE, F_MFLO, 0, 0, 1'b0);
    chk("mflo-hilosel", 32'(hist[3].hilosel), 32'd0);
    instr(OP_RTYPE, F_JR, 0, 0, 1'b0);
    chk("jr-pcsrc", 32'(hist[2].pcsrc), 32'b11);

    instr(OP_JAL, 6'd0, 0, 0, 1'b0);
`ifdef MC_CONTROLLER_JAL_EN
    chk("jal-regdst", 32'(hist[2].regdst), 32'b10);
    chk("jal-memtoreg", 32'(hist[2].memtoreg), 32'b11);
`else
    chk("jal-len", hist.size(), 2);
`endif
    instr(6'b111111, 6'd0, 0, 0, 1'b0);
    chk("unknown-len", hist.size(), 2);

    // reset in cycle 2 of MULT
    hist.delete();
    bus.op = OP_RTYPE; bus.funct = F_MULTU;
    step(f_fetch(1'b1), 1'b1, 1'b0);
    step(f_dec(), 1'b1, 1'b0);
    step(f_rex(F_MULTU), 1'b1, 1'b0);
    step(f_mult(), 1'b1, 1'b0);
    async_reset("rst-mult");

    // reset while waiting in MEMRD
    hist.delete();
    bus.op = OP_LW; bus.funct = '0;
    step(f_fetch(1'b1), 1'b1, 1'b0);
    step(f_dec(), 1'b1, 1'b0);
    step(f_adr(), 1'b1, 1'b0);
    step(f_mem(1'b0), 1'b0, 1'b0);
    async_reset("rst-memrd");

    instr(OP_RTYPE, F_ADD, 0, 0, 1'b0);
    chk("post-reset-add-len", hist.size(), 4);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
